// File: rtl/apb_fsm_controller_pkg.sv
// Shared definitions for the APB-side control stage of the AHB-APB bridge.
// Holds the bus widths, the AHB response code and the FSM state encoding.
// No ports.
package apb_fsm_controller_pkg;

    // Widths mirror the legacy definitions.v macros (WIDTH, SLAVES).
    localparam int WIDTH  = 32;
    localparam int SLAVES = 3;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // State encoding kept as plain constants so the legacy bridge code can
    // reuse the same values.
    typedef logic [2:0] apb_state_t;

    localparam apb_state_t ST_IDLE     = 3'd0;
    localparam apb_state_t ST_WWAIT    = 3'd1;
    localparam apb_state_t ST_READ     = 3'd2;
    localparam apb_state_t ST_WRITE    = 3'd3;
    localparam apb_state_t ST_WRITEP   = 3'd4;
    localparam apb_state_t ST_RENABLE  = 3'd5;
    localparam apb_state_t ST_WENABLE  = 3'd6;
    localparam apb_state_t ST_WENABLEP = 3'd7;

    // States from which a fresh AHB beat may start a new APB access.
    function automatic logic accepts_new(input apb_state_t s);
        return (s == ST_IDLE) || (s == ST_RENABLE) || (s == ST_WENABLE);
    endfunction

endpackage

// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB slave interface / APB fabric and the APB
// control FSM.
//   AHB side : valid, Haddr/Haddr1/Haddr2, Hwdata/Hwdata1, Hwrite, Hwritereg,
//              tempselx in; Hreadyout, Hrdata, Hresp out.
//   APB side : Prdata in; Pwrite, Penable, Pselx, Paddr, Pwdata out.
// Modport slave is the controller's view; master is the driving side.
interface apb_fsm_controller_if #(
    parameter int WIDTH  = apb_fsm_controller_pkg::WIDTH,
    parameter int SLAVES = apb_fsm_controller_pkg::SLAVES
);
    logic              valid;
    logic [WIDTH-1:0]  Haddr;
    logic [WIDTH-1:0]  Haddr1;
    logic [WIDTH-1:0]  Haddr2;
    logic [WIDTH-1:0]  Hwdata;
    logic [WIDTH-1:0]  Hwdata1;
    logic              Hwrite;
    logic              Hwritereg;
    logic [SLAVES-1:0] tempselx;
    logic [WIDTH-1:0]  Prdata;

    logic              Pwrite;
    logic              Penable;
    logic [SLAVES-1:0] Pselx;
    logic [WIDTH-1:0]  Paddr;
    logic [WIDTH-1:0]  Pwdata;
    logic              Hreadyout;
    logic [WIDTH-1:0]  Hrdata;
    logic [1:0]        Hresp;

    modport slave (
        input  valid, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
               Hwrite, Hwritereg, tempselx, Prdata,
        output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
    );

    modport master (
        output valid, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1,
               Hwrite, Hwritereg, tempselx, Prdata,
        input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB-side control stage of the AHB-APB bridge. Turns single and
// back-to-back AHB beats into APB SETUP/ENABLE phases and stalls the AHB
// master through Hreadyout while an access is in flight.
// Ports:
//   clock  - bridge clock, all state changes on posedge
//   Hreset - synchronous active-high reset
//   bus    - apb_fsm_controller_if.slave (AHB pipeline in, APB out)
// All APB outputs and Hreadyout are registered and loaded on the edge that
// enters the corresponding state; Hrdata/Hresp are combinational.
module apb_fsm_controller
    import apb_fsm_controller_pkg::*;
#(
    parameter int WIDTH  = apb_fsm_controller_pkg::WIDTH,
    parameter int SLAVES = apb_fsm_controller_pkg::SLAVES
) (
    input  logic                 clock,
    input  logic                 Hreset,
    apb_fsm_controller_if.slave  bus
);

    apb_state_t        state_q,   state_d;
    logic              pwrite_q,  pwrite_d;
    logic              penable_q, penable_d;
    logic [SLAVES-1:0] pselx_q,   pselx_d;
    logic [WIDTH-1:0]  paddr_q,   paddr_d;
    logic [WIDTH-1:0]  pwdata_q,  pwdata_d;
    logic              hready_q,  hready_d;

    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        pselx_d   = pselx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;

        if (accepts_new(state_q)) begin
            if (bus.valid && !bus.Hwrite) begin
                state_d   = ST_READ;
                paddr_d   = bus.Haddr;
                pwrite_d  = 1'b0;
                pselx_d   = bus.tempselx;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end else if (bus.valid && bus.Hwrite) begin
                // Write data arrives one cycle after the address, so park
                // here with the bus idle until Hwdata is valid.
                state_d   = ST_WWAIT;
                pselx_d   = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end else begin
                state_d   = ST_IDLE;
                pselx_d   = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_WWAIT: begin
                    // Address of the write beat is now one stage back.
                    paddr_d   = bus.Haddr1;
                    pwdata_d  = bus.Hwdata;
                    pwrite_d  = 1'b1;
                    pselx_d   = bus.tempselx;
                    penable_d = 1'b0;
                    if (bus.valid) begin
                        state_d  = ST_WRITEP;
                        hready_d = 1'b0;
                    end else begin
                        state_d  = ST_WRITE;
                        hready_d = 1'b1;
                    end
                end
                ST_READ: begin
                    state_d   = ST_RENABLE;
                    penable_d = 1'b1;
                    hready_d  = 1'b1;
                end
                ST_WRITE: begin
                    penable_d = 1'b1;
                    if (bus.valid) begin
                        state_d  = ST_WENABLEP;
                        hready_d = 1'b0;
                    end else begin
                        state_d  = ST_WENABLE;
                        hready_d = 1'b1;
                    end
                end
                ST_WRITEP: begin
                    state_d   = ST_WENABLEP;
                    penable_d = 1'b1;
                    hready_d  = 1'b0;
                end
                ST_WENABLEP: begin
                    if (!bus.Hwritereg) begin
                        state_d   = ST_READ;
                        paddr_d   = bus.Haddr;
                        pwrite_d  = 1'b0;
                        pselx_d   = bus.tempselx;
                        penable_d = 1'b0;
                        hready_d  = 1'b0;
                    end else begin
                        // Master was stalled a cycle, so the pending write
                        // beat sits two address stages / one data stage back.
                        paddr_d   = bus.Haddr2;
                        pwdata_d  = bus.Hwdata1;
                        pwrite_d  = 1'b1;
                        pselx_d   = bus.tempselx;
                        penable_d = 1'b0;
                        if (bus.valid) begin
                            state_d  = ST_WRITEP;
                            hready_d = 1'b0;
                        end else begin
                            state_d  = ST_WRITE;
                            hready_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    pselx_d   = '0;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pselx_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    assign bus.Pwrite    = pwrite_q;
    assign bus.Penable   = penable_q;
    assign bus.Pselx     = pselx_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hready_q;
    assign bus.Hrdata    = bus.Prdata;
    assign bus.Hresp     = HRESP_OKAY;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: drives the AHB pipeline signals by
// hand each cycle and compares APB/AHB outputs with hand-computed values.
module tb_apb_fsm_controller;
    import apb_fsm_controller_pkg::*;

    logic clock;
    logic Hreset;
    int   total;
    int   bad;

    apb_fsm_controller_if #(.WIDTH(32), .SLAVES(3)) bus ();

    apb_fsm_controller #(.WIDTH(32), .SLAVES(3)) dut (
        .clock  (clock),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic hw, input logic hwr,
                       input logic [31:0] a, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] d, input logic [31:0] d1, input logic [2:0] sel);
        bus.valid     = v;
        bus.Hwrite    = hw;
        bus.Hwritereg = hwr;
        bus.Haddr     = a;
        bus.Haddr1    = a1;
        bus.Haddr2    = a2;
        bus.Hwdata    = d;
        bus.Hwdata1   = d1;
        bus.tempselx  = sel;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Hreset = 1'b1;
        bus.Prdata = 32'h0;
        idle_in();
        cyc();
        cyc();
        chk("rst_pselx",   {29'b0, bus.Pselx}, 32'h0);
        chk("rst_penable", {31'b0, bus.Penable}, 32'h0);
        chk("rst_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        chk("rst_paddr",   bus.Paddr, 32'h0);
        chk("rst_pwdata",  bus.Pwdata, 32'h0);
        chk("rst_pwrite",  {31'b0, bus.Pwrite}, 32'h0);
        chk("rst_hresp",   {30'b0, bus.Hresp}, 32'h0);
        @(negedge clock);
        Hreset = 1'b0;

        // ---- single read
        bus.Prdata = 32'hDEAD_BEEF;
        drv(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        cyc();
        chk("rd_paddr",   bus.Paddr, 32'h8000_0010);
        chk("rd_pselx",   {29'b0, bus.Pselx}, 32'h1);
        chk("rd_penable", {31'b0, bus.Penable}, 32'h0);
        chk("rd_hready",  {31'b0, bus.Hreadyout}, 32'h0);
        chk("rd_pwrite",  {31'b0, bus.Pwrite}, 32'h0);
        idle_in();
        cyc();
        chk("rd_en_penable", {31'b0, bus.Penable}, 32'h1);
        chk("rd_en_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        chk("rd_en_paddr",   bus.Paddr, 32'h8000_0010);
        chk("rd_hrdata",     bus.Hrdata, 32'hDEAD_BEEF);
        cyc();
        chk("rd_idle_pselx",   {29'b0, bus.Pselx}, 32'h0);
        chk("rd_idle_penable", {31'b0, bus.Penable}, 32'h0);

        // ---- single write
        drv(1'b1, 1'b1, 1'b0, 32'h8400_0004, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010);
        cyc();
        chk("wr_wait_pselx",  {29'b0, bus.Pselx}, 32'h0);
        chk("wr_wait_hready", {31'b0, bus.Hreadyout}, 32'h1);
        drv(1'b0, 1'b0, 1'b1, 32'h0, 32'h8400_0004, 32'h0, 32'h1234_5678, 32'h0, 3'b010);
        cyc();
        chk("wr_paddr",   bus.Paddr, 32'h8400_0004);
        chk("wr_pwdata",  bus.Pwdata, 32'h1234_5678);
        chk("wr_pwrite",  {31'b0, bus.Pwrite}, 32'h1);
        chk("wr_pselx",   {29'b0, bus.Pselx}, 32'h2);
        chk("wr_penable", {31'b0, bus.Penable}, 32'h0);
        chk("wr_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        idle_in();
        cyc();
        chk("wr_en_penable", {31'b0, bus.Penable}, 32'h1);
        chk("wr_en_pwdata",  bus.Pwdata, 32'h1234_5678);
        chk("wr_en_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        cyc();
        chk("wr_idle_pselx", {29'b0, bus.Pselx}, 32'h0);

        // ---- back-to-back writes
        drv(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        cyc();
        chk("bw_wwait_hready", {31'b0, bus.Hreadyout}, 32'h1);
        drv(1'b1, 1'b1, 1'b1, 32'h8000_0004, 32'h8000_0000, 32'h0, 32'h11, 32'h0, 3'b001);
        cyc();
        chk("bw_p_paddr",  bus.Paddr, 32'h8000_0000);
        chk("bw_p_pwdata", bus.Pwdata, 32'h11);
        chk("bw_p_hready", {31'b0, bus.Hreadyout}, 32'h0);
        chk("bw_p_penable", {31'b0, bus.Penable}, 32'h0);
        drv(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0004, 32'h8000_0000, 32'h22, 32'h11, 3'b001);
        cyc();
        chk("bw_ep_penable", {31'b0, bus.Penable}, 32'h1);
        chk("bw_ep_hready",  {31'b0, bus.Hreadyout}, 32'h0);
        chk("bw_ep_paddr",   bus.Paddr, 32'h8000_0000);
        drv(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0004, 32'h0, 32'h22, 3'b001);
        cyc();
        chk("bw_w2_paddr",   bus.Paddr, 32'h8000_0004);
        chk("bw_w2_pwdata",  bus.Pwdata, 32'h22);
        chk("bw_w2_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        chk("bw_w2_penable", {31'b0, bus.Penable}, 32'h0);
        idle_in();
        cyc();
        chk("bw_e2_penable", {31'b0, bus.Penable}, 32'h1);
        chk("bw_e2_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        cyc();
        chk("bw_idle_pselx", {29'b0, bus.Pselx}, 32'h0);

        // ---- write followed by read
        drv(1'b1, 1'b1, 1'b0, 32'h8000_00A0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        cyc();
        drv(1'b1, 1'b0, 1'b1, 32'h8000_00A4, 32'h8000_00A0, 32'h0, 32'h33, 32'h0, 3'b001);
        cyc();
        chk("wr_rd_p_paddr",  bus.Paddr, 32'h8000_00A0);
        chk("wr_rd_p_pwrite", {31'b0, bus.Pwrite}, 32'h1);
        drv(1'b0, 1'b0, 1'b0, 32'h8000_00A4, 32'h0, 32'h0, 32'h0, 32'h33, 3'b100);
        cyc();
        chk("wr_rd_ep_penable", {31'b0, bus.Penable}, 32'h1);
        chk("wr_rd_ep_pwdata",  bus.Pwdata, 32'h33);
        cyc();
        chk("wr_rd_r_paddr",  bus.Paddr, 32'h8000_00A4);
        chk("wr_rd_r_pwrite", {31'b0, bus.Pwrite}, 32'h0);
        chk("wr_rd_r_pselx",  {29'b0, bus.Pselx}, 32'h4);
        chk("wr_rd_r_pwdata", bus.Pwdata, 32'h33);
        chk("wr_rd_r_hready", {31'b0, bus.Hreadyout}, 32'h0);
        idle_in();
        cyc();
        chk("wr_rd_en_penable", {31'b0, bus.Penable}, 32'h1);
        cyc();

        // ---- three back-to-back reads
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ra;
            ra = 32'h8000_0100 + 32'(i * 4);
            drv(1'b1, 1'b0, 1'b0, ra, 32'h0, 32'h0, 32'h0, 32'h0, 3'b010);
            cyc();
            chk("br_r_penable", {31'b0, bus.Penable}, 32'h0);
            chk("br_r_hready",  {31'b0, bus.Hreadyout}, 32'h0);
            chk("br_r_paddr",   bus.Paddr, ra);
            idle_in();
            cyc();
            chk("br_e_penable", {31'b0, bus.Penable}, 32'h1);
            chk("br_e_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        end
        cyc();

        // ---- reset during a write
        drv(1'b1, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001);
        cyc();
        drv(1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0200, 32'h0, 32'h55, 32'h0, 3'b001);
        cyc();
        chk("rw_pselx_pre", {29'b0, bus.Pselx}, 32'h1);
        Hreset = 1'b1;
        cyc();
        cyc();
        chk("rw_pselx",   {29'b0, bus.Pselx}, 32'h0);
        chk("rw_penable", {31'b0, bus.Penable}, 32'h0);
        chk("rw_hready",  {31'b0, bus.Hreadyout}, 32'h1);
        chk("rw_paddr",   bus.Paddr, 32'h0);
        chk("rw_state",   {29'b0, dut.state_q}, {29'b0, ST_IDLE});
        @(negedge clock);
        Hreset = 1'b0;
        idle_in();
        cyc();
        chk("rw_post_pselx",  {29'b0, bus.Pselx}, 32'h0);
        chk("rw_post_hready", {31'b0, bus.Hreadyout}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
APB-side control stage of the AHB-APB bridge. It sits directly downstream of the AHB slave interface, which supplies a valid strobe, pipelined addresses/data and a decoded slave select. It sequences single and back-to-back AHB reads and writes into APB SETUP/ENABLE phases and drives Hreadyout to stall the AHB master while an APB access is in flight.

Parameters:
WIDTH, 32, address/data width (matches `WIDTH in definitions.v)
SLAVES, 3, number of APB slaves, one-hot Pselx width (matches `SLAVES)

Ports:
clock  input  1  bridge clock (HCLK domain); all state changes on posedge
Hreset  input  1  synchronous, active-high reset
valid  input  1  AHB slave interface: current AHB beat is a NONSEQ/SEQ hit in bridge range
Haddr  input  WIDTH  current AHB address
Haddr1  input  WIDTH  Haddr delayed 1 cycle
Haddr2  input  WIDTH  Haddr delayed 2 cycles
Hwdata  input  WIDTH  current AHB write data
Hwdata1  input  WIDTH  Hwdata delayed 1 cycle
Hwrite  input  1  current AHB direction
Hwritereg  input  1  Hwrite delayed 1 cycle
tempselx  input  SLAVES  one-hot slave decode of the pipelined address
Prdata  input  WIDTH  APB read data
Pwrite  output  1  APB direction
Penable  output  1  APB enable
Pselx  output  SLAVES  APB one-hot select
Paddr  output  WIDTH  APB address
Pwdata  output  WIDTH  APB write data
Hreadyout  output  1  AHB ready to master
Hrdata  output  WIDTH  AHB read data
Hresp  output  2  AHB response

Behaviour:
- Hreset=1 at posedge: state to ST_IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1. Reset overrides any in-flight transfer; no APB completion is owed.
- Hresp is tied to 2'b00 (OKAY). Hrdata = Prdata, combinational.
- All other outputs are registered. Each output value is loaded on the same edge as the state transition that enters the state.
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- Transitions:
  - IDLE, RENABLE, WENABLE: valid&!Hwrite -> READ; valid&Hwrite -> WWAIT; else -> IDLE.
  - WWAIT: valid -> WRITEP; else -> WRITE.
  - READ -> RENABLE.
  - WRITE: valid -> WENABLEP; else -> WENABLE.
  - WRITEP -> WENABLEP.
  - WENABLEP: !Hwritereg -> READ; Hwritereg&valid -> WRITEP; Hwritereg&!valid -> WRITE.
- Outputs on entry:
  - READ: Paddr=Haddr, Pwrite=0, Pselx=tempselx, Penable=0, Hreadyout=0.
  - WWAIT: Pselx=0, Penable=0, Hreadyout=1.
  - WRITE or WRITEP from WWAIT: Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Pselx=tempselx, Penable=0.
  - WRITE or WRITEP from WENABLEP: Paddr=Haddr2, Pwdata=Hwdata1; other values as from WWAIT.
  - Hreadyout on entry: WRITE=1, WRITEP=0.
  - RENABLE, WENABLE, WENABLEP: Penable=1; Paddr, Pwdata, Pselx and Pwrite held.
  - Hreadyout on entry: RENABLE=1, WENABLE=1, WENABLEP=0.
  - IDLE: Pselx=0, Penable=0, Hreadyout=1.
- Latency:
  - Read: 2 cycles of APB (SETUP+ENABLE); Hreadyout low for exactly 1 cycle.
  - Single write: WWAIT+SETUP+ENABLE. Write data is always one cycle behind the address (AHB pipeline), hence the WWAIT state.
- No APB wait states: Pready is not used; every ENABLE phase is one cycle.
- Pselx is never multi-hot; tempselx=0 with valid=1 is not generated upstream and needs no handling.

Decomposition:
- Shared package bridge_pkg: state enum apb_state_t (8 states above), HRESP_OKAY constant, WIDTH and SLAVES as package parameters mirroring definitions.v.
- No sub-module: one next-state always_comb and one registered output always_ff.
- Top level bridge_top instantiates ahb_slave_interface and apb_fsm_controller.

Test Plan:
- Reset: Hreset=1 for 2 cycles during a write -> Pselx=0, Penable=0, Hreadyout=1, state IDLE next edge.
- Single read: valid=1, Hwrite=0, Haddr=32'h8000_0010, tempselx=3'b001, Prdata=32'hDEAD_BEEF.
  - Cycle+1: Paddr=8000_0010, Psel=001, Penable=0, Hreadyout=0.
  - Cycle+2: Penable=1, Hreadyout=1, Hrdata=DEAD_BEEF.
  - Cycle+3: IDLE, Pselx=0.
- Single write: valid=1, Hwrite=1, Haddr=32'h8400_0004, then Hwdata=32'h1234_5678.
  - WWAIT, then SETUP with Paddr=8400_0004, Pwdata=1234_5678, Pwrite=1.
  - Then ENABLE, then IDLE.
- Back-to-back writes to 8000_0000/8000_0004 (data 11/22):
  - Path WWAIT -> WRITEP -> WENABLEP -> WRITE -> WENABLE.
  - Second SETUP drives Paddr=8000_0004, Pwdata=22.
  - Hreadyout low during WRITEP and WENABLEP.
- Write followed by read:
  - WENABLEP with Hwritereg=0 -> READ.
  - Read Paddr equals the read address; no write data corruption.
- Back-to-back reads (3 beats): READ/RENABLE alternate three times; Penable toggles 0,1,0,1,0,1; Hreadyout 0,1,0,1,0,1.
